// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: two debounced buttons drive a run/lap/stop/clear FSM
// and select the live or lap-frozen count for the display.

module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             db, db_q;
    logic             sync;

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt    <= '0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples
            if (sync != db) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db  <= sync;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            db_q  <= db;
            press <= db & ~db_q;
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMER_W         = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               btn_start_stop,
    input  logic               btn_lap_reset,
    input  logic [TIMER_W-1:0] timer_in,
    output logic               run,
    output logic               clr,
    output logic [TIMER_W-1:0] disp_timer,
    output logic               lap_valid,
    output logic [1:0]         state
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_LAP  = 2'b10;
    localparam logic [1:0] S_STOP = 2'b11;

    logic [1:0]         btn_raw;
    logic [1:0]         press;
    logic               press_ss, press_lr;
    logic [1:0]         nxt_state;
    logic               nxt_clr, cap_lap;
    logic [TIMER_W-1:0] lap_reg;

    assign btn_raw = {btn_lap_reset, btn_start_stop};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .resetn(resetn),
            .btn   (btn_raw[g]),
            .press (press[g])
        );
    end

    assign press_ss = press[0];
    assign press_lr = press[1];

    // start_stop has priority; a coincident lap_reset press is dropped entirely
    always_comb begin
        nxt_state = state;
        nxt_clr   = 1'b0;
        cap_lap   = 1'b0;
        case (state)
            S_IDLE: begin
                if (press_ss)      nxt_state = S_RUN;
                else if (press_lr) nxt_clr = 1'b1;
            end
            S_RUN: begin
                if (press_ss)      nxt_state = S_STOP;
                else if (press_lr) begin
                    nxt_state = S_LAP;
                    cap_lap   = 1'b1;
                end
            end
            S_LAP: begin
                if (press_ss)      nxt_state = S_STOP;
                else if (press_lr) nxt_state = S_RUN;
            end
            default: begin
                if (press_ss)      nxt_state = S_RUN;
                else if (press_lr) begin
                    nxt_state = S_IDLE;
                    nxt_clr   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            run       <= 1'b0;
            clr       <= 1'b0;
            lap_valid <= 1'b0;
            lap_reg   <= '0;
        end else begin
            state     <= nxt_state;
            run       <= (nxt_state == S_RUN) || (nxt_state == S_LAP);
            clr       <= nxt_clr;
            lap_valid <= (nxt_state == S_LAP);
            if (cap_lap) lap_reg <= timer_in;
        end
    end

    assign disp_timer = lap_valid ? lap_reg : timer_in;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with short debounce: vector table via scoreboard queue
// plus hand sequences for glitch rejection, press latency and mid-debounce reset.

module tb_stopwatch_ctrl;
    localparam int DC = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          bss = 1'b0;
    logic          blr = 1'b0;
    logic [TW-1:0] timer_in = '0;
    logic          run, clr, lap_valid;
    logic [TW-1:0] disp_timer;
    logic [1:0]    state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .TIMER_W(TW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .btn_start_stop(bss),
        .btn_lap_reset (blr),
        .timer_in      (timer_in),
        .run           (run),
        .clr           (clr),
        .disp_timer    (disp_timer),
        .lap_valid     (lap_valid),
        .state         (state)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int clr_seen = 0;

    always @(negedge clk) if (clr) clr_seen <= clr_seen + 1;

    typedef struct {
        logic          ss, lr;
        logic [TW-1:0] t;
        logic [1:0]    st;
        logic          run, lv;
        logic [TW-1:0] disp;
        int            clrs;
    } vec_t;

    vec_t tbl[15];
    vec_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(logic ss, logic lr, logic [TW-1:0] t, logic [1:0] st,
                                logic r, logic lv, logic [TW-1:0] d, int c);
        vec_t v;
        v.ss = ss; v.lr = lr; v.t = t; v.st = st;
        v.run = r; v.lv = lv; v.disp = d; v.clrs = c;
        return v;
    endfunction

    initial begin
        int   c0, lat, chg, moved;
        logic [1:0] prev;
        vec_t v, e;

        //        ss lr timer         state run lv disp         clrs
        tbl[0]  = mk(0, 1, 32'h0001_0203, 2'b10, 1, 1, 32'h0001_0203, 0);
        tbl[1]  = mk(0, 0, 32'h0001_0250, 2'b10, 1, 1, 32'h0001_0203, 0);
        tbl[2]  = mk(0, 1, 32'h0001_0300, 2'b01, 1, 0, 32'h0001_0300, 0);
        tbl[3]  = mk(1, 0, 32'h0001_0400, 2'b11, 0, 0, 32'h0001_0400, 0);
        tbl[4]  = mk(0, 1, 32'h0001_0400, 2'b00, 0, 0, 32'h0001_0400, 1);
        tbl[5]  = mk(0, 1, 32'h0000_0000, 2'b00, 0, 0, 32'h0000_0000, 1);
        tbl[6]  = mk(1, 0, 32'h0000_0005, 2'b01, 1, 0, 32'h0000_0005, 0);
        tbl[7]  = mk(1, 1, 32'h0000_0006, 2'b11, 0, 0, 32'h0000_0006, 0);
        tbl[8]  = mk(1, 0, 32'h0000_0007, 2'b01, 1, 0, 32'h0000_0007, 0);
        tbl[9]  = mk(1, 1, 32'h0000_0008, 2'b11, 0, 0, 32'h0000_0008, 0);
        tbl[10] = mk(1, 0, 32'h0000_0009, 2'b01, 1, 0, 32'h0000_0009, 0);
        tbl[11] = mk(0, 1, 32'h00AB_CDEF, 2'b10, 1, 1, 32'h00AB_CDEF, 0);
        tbl[12] = mk(1, 0, 32'h0000_0011, 2'b11, 0, 0, 32'h0000_0011, 0);
        tbl[13] = mk(1, 0, 32'h0000_0012, 2'b01, 1, 0, 32'h0000_0012, 0);
        tbl[14] = mk(0, 1, 32'h00FF_0000, 2'b10, 1, 1, 32'h00FF_0000, 0);

        // reset values
        timer_in = 32'h0000_1234;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        chk("rst_lap_valid", 32'(lap_valid), 32'd0);
        chk("rst_disp", disp_timer, 32'h0000_1234);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // short glitches never reach the FSM
        moved = 0;
        for (int k = 0; k < 3; k++) begin
            bss = 1'b1;
            repeat (2) @(negedge clk) if (state !== 2'b00 || run !== 1'b0) moved++;
            bss = 1'b0;
            repeat (3) @(negedge clk) if (state !== 2'b00 || run !== 1'b0) moved++;
        end
        repeat (10) @(negedge clk) if (state !== 2'b00 || run !== 1'b0) moved++;
        chk("glitch_no_move", 32'(moved), 32'd0);

        // held button: one press, RUN after 2+DC+1+1 cycles (+-1)
        bss = 1'b1;
        lat = -1; chg = 0; prev = state;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (state !== prev) begin
                chg++;
                if (lat < 0) lat = c;
            end
            prev = state;
        end
        chk("hold_latency_ok", 32'((lat >= DC + 3) && (lat <= DC + 5)), 32'd1);
        chk("hold_one_change", 32'(chg), 32'd1);
        chk("hold_state", 32'(state), 32'd1);
        chk("hold_run", 32'(run), 32'd1);
        bss = 1'b0;
        repeat (12) @(negedge clk);
        chk("release_state", 32'(state), 32'd1);

        // table: expectations queued when driven, popped after settling
        for (int i = 0; i < 15; i++) begin
            v = tbl[i];
            sbq.push_back(v);
            timer_in = v.t;
            bss = v.ss;
            blr = v.lr;
            c0 = clr_seen;
            repeat (10) @(negedge clk);
            bss = 1'b0;
            blr = 1'b0;
            repeat (12) @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(e.st));
            chk($sformatf("v%0d_run", i), 32'(run), 32'(e.run));
            chk($sformatf("v%0d_lap_valid", i), 32'(lap_valid), 32'(e.lv));
            chk($sformatf("v%0d_disp", i), disp_timer, e.disp);
            chk($sformatf("v%0d_clr_cycles", i), 32'(clr_seen - c0), 32'(e.clrs));
            if (i == 7 || i == 9)
                chk($sformatf("v%0d_lap_reg_kept", i), dut.lap_reg, 32'h0001_0203);
        end

        // reset mid-debounce of a lap press while in LAP
        timer_in = 32'h0000_0777;
        blr = 1'b1;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_run", 32'(run), 32'd0);
        chk("midrst_clr", 32'(clr), 32'd0);
        chk("midrst_lap_valid", 32'(lap_valid), 32'd0);
        chk("midrst_disp", disp_timer, 32'h0000_0777);
        blr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        c0 = clr_seen;
        moved = 0;
        repeat (20) @(negedge clk) if (state !== 2'b00 || run !== 1'b0) moved++;
        chk("postrst_no_move", 32'(moved), 32'd0);
        chk("postrst_no_clr", 32'(clr_seen - c0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
